// File: rtl/instr_dispatch.sv
// instr_dispatch: fetches instructions into a first-word-fall-through queue,
// decodes the head opcode and issues it to one of NUM_ENG engine channels.
// Handles NOP, SYNC barrier, END and flags unknown opcodes.
module instr_dispatch #(
  parameter int INSTR_WIDTH = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int NUM_ENG     = 4,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_enable,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  output logic                          fetch_req,
  output logic [ADDR_WIDTH-1:0]         fetch_addr,
  input  logic [INSTR_WIDTH-1:0]        instr_in,
  input  logic                          instr_valid,
  output logic [INSTR_WIDTH-1:0]        eng_instr,
  output logic [NUM_ENG-1:0]            eng_start,
  input  logic [NUM_ENG-1:0]            eng_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err_opcode
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_SYNC = 8'hF0;
  localparam logic [7:0] OP_END  = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SYNC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    fetch_req_q, fetch_req_d;
  logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic                    outstanding_q, outstanding_d;
  logic                    end_fetched_q, end_fetched_d;
  logic                    end_pending_q, end_pending_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [INSTR_WIDTH-1:0]  eng_instr_q, eng_instr_d;
  logic [NUM_ENG-1:0]      eng_start_q, eng_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [INSTR_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

  logic [INSTR_WIDTH-1:0]  head;
  logic [7:0]              head_opc;
  logic [7:0]              in_opc;
  logic                    head_valid;
  logic [NUM_ENG-1:0]      target_vec;
  logic                    is_dispatch;
  logic                    target_free;
  logic                    push;
  logic                    pop;

  assign head       = fifo_mem[rd_ptr_q];
  assign head_opc   = head[INSTR_WIDTH-1 -: 8];
  assign in_opc     = instr_in[INSTR_WIDTH-1 -: 8];
  assign head_valid = (count_q != '0);

  // One-hot engine target of the head opcode (opcode gi+1 selects engine gi).
  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_target
    assign target_vec[gi] = (head_opc == 8'(gi + 1));
  end

  assign is_dispatch = |target_vec;
  // An engine started last cycle stays blocked until its busy has had time to rise.
  assign target_free = ~|(target_vec & (eng_busy | eng_start_q));
  // Only a response to our own outstanding request is accepted.
  assign push = ((state_q == S_RUN) || (state_q == S_SYNC)) && acc_enable
                && outstanding_q && instr_valid;

  // Queue storage: write-only on push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= instr_in;
  end

  // Next-state logic for the control FSM, fetcher, queue and issue port.
  always_comb begin
    state_d       = state_q;
    fetch_req_d   = 1'b0;
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    end_fetched_d = end_fetched_q;
    end_pending_d = end_pending_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    eng_instr_d   = eng_instr_q;
    eng_start_d   = '0;
    err_d         = err_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_enable) begin
          state_d       = S_RUN;
          fetch_addr_d  = base_addr;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          count_d       = '0;
          err_d         = 1'b0;
          end_fetched_d = 1'b0;
          end_pending_d = 1'b0;
          outstanding_d = 1'b0;
        end
      end
      S_RUN, S_SYNC: begin
        if (!acc_enable) begin
          // Abort: drop queue contents and forget any request in flight.
          state_d       = S_IDLE;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          count_d       = '0;
          outstanding_d = 1'b0;
        end else begin
          if (push) begin
            wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            fetch_addr_d  = fetch_addr_q + ADDR_WIDTH'(1);
            outstanding_d = 1'b0;
            if (in_opc == OP_END) end_fetched_d = 1'b1;
          end
          // A request is only made with a free slot, so a push never overflows.
          if (!outstanding_q && !end_fetched_q && (count_q < DEPTH_C)) begin
            fetch_req_d   = 1'b1;
            outstanding_d = 1'b1;
          end
          if (state_q == S_RUN) begin
            if (head_valid) begin
              if (is_dispatch) begin
                if (target_free) begin
                  pop         = 1'b1;
                  eng_start_d = target_vec;
                  eng_instr_d = head;
                end
              end else if (head_opc == OP_NOP) begin
                pop = 1'b1;
              end else if (head_opc == OP_SYNC) begin
                pop     = 1'b1;
                state_d = S_SYNC;
              end else if (head_opc == OP_END) begin
                pop           = 1'b1;
                state_d       = S_SYNC;
                end_pending_d = 1'b1;
              end else begin
                pop   = 1'b1;
                err_d = 1'b1;
              end
            end
          end else if ((eng_busy == '0) && (eng_start_q == '0)) begin
            state_d = end_pending_q ? S_DONE : S_RUN;
          end
          if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end
      S_DONE: begin
        if (!acc_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_SYNC);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fetch_req_q   <= 1'b0;
      fetch_addr_q  <= '0;
      outstanding_q <= 1'b0;
      end_fetched_q <= 1'b0;
      end_pending_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      eng_instr_q   <= '0;
      eng_start_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_req_q   <= fetch_req_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      end_fetched_q <= end_fetched_d;
      end_pending_q <= end_pending_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      eng_instr_q   <= eng_instr_d;
      eng_start_q   <= eng_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;
  assign eng_instr  = eng_instr_q;
  assign eng_start  = eng_start_q;
  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_opcode = err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: drives programs through a memory responder and engine
// models, and compares the issue stream against the program order.
module tb_instr_dispatch;
  localparam int IW = 64;
  localparam int FD = 16;
  localparam int NE = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          acc_enable = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [IW-1:0] instr_in = '0;
  logic          instr_valid = 1'b0;
  logic [IW-1:0] eng_instr;
  logic [NE-1:0] eng_start;
  logic [NE-1:0] eng_busy;
  logic [4:0]    fifo_count;
  logic          busy, done, err_opcode;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Program memory and reference issue stream.
  logic [IW-1:0] prog [64];
  int            prog_len = 0;
  logic [IW-1:0] exp_instr [$];
  int            exp_eng [$];

  // Observed issues.
  logic [IW-1:0] iss_instr [$];
  int            iss_eng [$];
  int            iss_cyc [$];
  int            onehot_err = 0;
  int            max_count = 0;

  // Engine models.
  logic [NE-1:0] force_busy = '0;
  logic [NE-1:0] cnt_busy = '0;
  int            ecnt [NE] = '{default: 0};
  int            lat [NE] = '{default: 2};
  bit            rand_lat = 1'b0;
  bit            rand_mem = 1'b0;
  assign eng_busy = force_busy | cnt_busy;

  // Memory responder state.
  bit            pend = 1'b0;
  int            wcnt = 0;
  logic [AW-1:0] paddr = '0;

  instr_dispatch #(.INSTR_WIDTH(IW), .FIFO_DEPTH(FD), .NUM_ENG(NE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .acc_enable(acc_enable), .base_addr(base_addr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr_in(instr_in),
    .instr_valid(instr_valid), .eng_instr(eng_instr), .eng_start(eng_start),
    .eng_busy(eng_busy), .fifo_count(fifo_count), .busy(busy), .done(done),
    .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Issue monitor.
  always @(negedge clk) begin
    if (eng_start != '0) begin
      if ($countones(eng_start) != 1) onehot_err++;
      for (int e = 0; e < NE; e++) if (eng_start[e]) iss_eng.push_back(e);
      iss_instr.push_back(eng_instr);
      iss_cyc.push_back(cyc);
      $display("issue cyc=%0d start=%b instr=%h", cyc, eng_start, eng_instr);
    end
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
  end

  // Engines: busy for a latency after each start.
  always @(negedge clk) begin
    for (int e = 0; e < NE; e++) begin
      if (eng_start[e]) ecnt[e] = rand_lat ? int'($urandom_range(0, 12)) : lat[e];
      else if (ecnt[e] > 0) ecnt[e]--;
      cnt_busy[e] = (ecnt[e] > 0);
    end
  end

  // Instruction memory: answers each request after 0..5 extra cycles.
  always @(negedge clk) begin
    int ii;
    if (!acc_enable || !rst) begin
      pend = 1'b0;
      instr_valid = 1'b0;
    end else begin
      instr_valid = 1'b0;
      if (pend) begin
        if (wcnt == 0) begin
          ii = int'(AW'(paddr - base_addr));
          instr_in = (ii < prog_len) ? prog[ii] : '0;
          instr_valid = 1'b1;
          pend = 1'b0;
        end else begin
          wcnt--;
        end
      end
      if (fetch_req) begin
        pend  = 1'b1;
        paddr = fetch_addr;
        wcnt  = rand_mem ? int'($urandom_range(0, 5)) : 0;
      end
    end
  end

  task automatic load_prog(input logic [7:0] ops [$], input int tag);
    prog_len = ops.size();
    for (int i = 0; i < prog_len; i++) prog[i] = {ops[i], 56'(tag * 256 + i)};
    exp_instr.delete();
    exp_eng.delete();
    for (int i = 0; i < prog_len; i++) begin
      if (ops[i] == 8'hFF) break;
      if (ops[i] >= 8'd1 && ops[i] <= 8'(NE)) begin
        exp_instr.push_back(prog[i]);
        exp_eng.push_back(int'(ops[i]) - 1);
      end
    end
  endtask

  task automatic clear_obs();
    iss_instr.delete();
    iss_eng.delete();
    iss_cyc.delete();
    onehot_err = 0;
    max_count = 0;
  endtask

  function automatic int issue_mismatches();
    int m = 0;
    if (iss_instr.size() != exp_instr.size()) return 1000 + iss_instr.size();
    for (int i = 0; i < iss_instr.size(); i++)
      if (iss_instr[i] !== exp_instr[i] || iss_eng[i] != exp_eng[i]) m++;
    return m + onehot_err;
  endfunction

  task automatic run_to_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_req: got %b want 0", fetch_req); end
    n_checks++; if (fetch_addr !== 16'h0) begin n_fail++; $display("FAIL reset_fetch_addr: got %h want 0", fetch_addr); end
    n_checks++; if (eng_instr !== 64'h0) begin n_fail++; $display("FAIL reset_eng_instr: got %h want 0", eng_instr); end
    n_checks++; if (eng_start !== 4'h0) begin n_fail++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_checks++; if ({busy, done, err_opcode} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, err_opcode}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] ops [$];
    bit ok;
    int bad;
    ops = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    load_prog(ops, 1);
    base_addr = 16'h0010;
    rand_mem = 1'b0; rand_lat = 1'b0;
    for (int e = 0; e < NE; e++) lat[e] = 3;
    force_busy = 4'hF;
    clear_obs();
    acc_enable = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || fetch_req !== 1'b0) begin n_fail++; $display("FAIL basic_enter_run: busy=%b fetch_req=%b want 1 0", busy, fetch_req); end
    @(negedge clk);
    n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0010) begin n_fail++; $display("FAIL basic_first_fetch: req=%b addr=%h want 1 0010", fetch_req, fetch_addr); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo_count == 5'd5) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_fill: fifo_count=%0d want 5", fifo_count); end
    force_busy = 4'h0;
    run_to_done(300, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done: done=%b want 1", done); end
    n_checks++; if (issue_mismatches() !== 0) begin n_fail++; $display("FAIL basic_order: mismatches=%0d want 0", issue_mismatches()); end
    bad = (iss_cyc.size() == 4) ? 0 : 1;
    for (int i = 1; i < iss_cyc.size(); i++) if (iss_cyc[i] != iss_cyc[i-1] + 1) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL basic_consecutive: gaps=%0d issues=%0d want 0 4", bad, iss_cyc.size()); end
    n_checks++; if (fetch_addr !== 16'h0015) begin n_fail++; $display("FAIL basic_fetch_addr: got %h want 0015", fetch_addr); end
    n_checks++; if (busy !== 1'b0 || err_opcode !== 1'b0) begin n_fail++; $display("FAIL basic_status: busy=%b err=%b want 0 0", busy, err_opcode); end
    acc_enable = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_idle: done=%b want 0", done); end
  endtask

  task automatic test_busy_stall();
    logic [7:0] ops [$];
    bit ok;
    ops = {8'h01, 8'h01, 8'h02, 8'hFF};
    load_prog(ops, 2);
    base_addr = 16'h0100;
    for (int e = 0; e < NE; e++) lat[e] = 2;
    lat[0] = 20;
    clear_obs();
    acc_enable = 1'b1;
    run_to_done(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_done: done=%b want 1", done); end
    n_checks++; if (issue_mismatches() !== 0) begin n_fail++; $display("FAIL stall_order: mismatches=%0d want 0", issue_mismatches()); end
    if (iss_cyc.size() == 3) begin
      n_checks++; if (iss_cyc[1] - iss_cyc[0] !== 21) begin n_fail++; $display("FAIL stall_second_issue: gap=%0d want 21", iss_cyc[1] - iss_cyc[0]); end
      n_checks++; if (iss_cyc[2] - iss_cyc[1] !== 1) begin n_fail++; $display("FAIL stall_follow_issue: gap=%0d want 1", iss_cyc[2] - iss_cyc[1]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL stall_count: issues=%0d want 3", iss_cyc.size());
    end
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ops [$];
    bit ok;
    ops = {};
    for (int i = 0; i < 40; i++) ops.push_back(8'($urandom_range(0, NE)));
    ops.push_back(8'hFF);
    load_prog(ops, 3);
    base_addr = 16'hFFF0;
    rand_mem = 1'b1; rand_lat = 1'b1;
    clear_obs();
    acc_enable = 1'b1;
    run_to_done(5000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_done: done=%b want 1", done); end
    n_checks++; if (issue_mismatches() !== 0) begin n_fail++; $display("FAIL rand_order: mismatches=%0d issued=%0d want 0 %0d", issue_mismatches(), iss_instr.size(), exp_instr.size()); end
    n_checks++; if (max_count > FD) begin n_fail++; $display("FAIL rand_max_count: got %0d want <=%0d", max_count, FD); end
    n_checks++; if (fetch_addr !== 16'(16'hFFF0 + 41)) begin n_fail++; $display("FAIL rand_fetch_wrap: got %h want %h", fetch_addr, 16'(16'hFFF0 + 41)); end
    rand_mem = 1'b0; rand_lat = 1'b0;
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sync();
    logic [7:0] ops [$];
    bit ok;
    int gap;
    ops = {8'h02, 8'hF0, 8'h03, 8'hFF};
    load_prog(ops, 4);
    base_addr = 16'h0200;
    for (int e = 0; e < NE; e++) lat[e] = 2;
    lat[1] = 10;
    clear_obs();
    acc_enable = 1'b1;
    ok = 1'b0; gap = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (!busy) gap++;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sync_done: done=%b want 1", done); end
    n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL sync_busy_held: low_cycles=%0d want 0", gap); end
    n_checks++; if (issue_mismatches() !== 0) begin n_fail++; $display("FAIL sync_order: mismatches=%0d want 0", issue_mismatches()); end
    if (iss_cyc.size() == 2) begin
      n_checks++; if (iss_cyc[1] < iss_cyc[0] + 12) begin n_fail++; $display("FAIL sync_barrier: gap=%0d want >=12", iss_cyc[1] - iss_cyc[0]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL sync_count: issues=%0d want 2", iss_cyc.size());
    end
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_err_opcode();
    logic [7:0] ops [$];
    bit ok;
    ops = {8'h01, 8'h7E, 8'h02, 8'hFF};
    load_prog(ops, 5);
    base_addr = 16'h0300;
    for (int e = 0; e < NE; e++) lat[e] = 2;
    clear_obs();
    acc_enable = 1'b1;
    run_to_done(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_done: done=%b want 1", done); end
    n_checks++; if (err_opcode !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err_opcode); end
    n_checks++; if (issue_mismatches() !== 0) begin n_fail++; $display("FAIL err_order: mismatches=%0d want 0", issue_mismatches()); end
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (err_opcode !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_opcode); end
    ops = {8'h03, 8'hFF};
    load_prog(ops, 6);
    clear_obs();
    acc_enable = 1'b1;
    @(negedge clk);
    n_checks++; if (err_opcode !== 1'b0) begin n_fail++; $display("FAIL err_restart_clear: got %b want 0", err_opcode); end
    run_to_done(200, ok);
    n_checks++; if (ok !== 1'b1 || issue_mismatches() !== 0) begin n_fail++; $display("FAIL err_restart_run: done=%b mismatches=%0d want 1 0", done, issue_mismatches()); end
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] ops [$];
    bit ok;
    ops = {};
    for (int i = 0; i < 12; i++) ops.push_back(8'h01);
    ops.push_back(8'hFF);
    load_prog(ops, 7);
    base_addr = 16'h0400;
    force_busy = 4'b0001;
    clear_obs();
    acc_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_count == 5'd5) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_fill: fifo_count=%0d want 5", fifo_count); end
    acc_enable = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_count !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: count=%0d busy=%b want 0 0", fifo_count, busy); end
    n_checks++; if (fetch_req !== 1'b0 || eng_start !== 4'h0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: req=%b start=%b done=%b want 0 0 0", fetch_req, eng_start, done); end
    acc_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_count >= 5'd2) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_refill: fifo_count=%0d want >=2", fifo_count); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_count !== 5'd0 || fetch_addr !== 16'h0 || eng_instr !== 64'h0) begin n_fail++; $display("FAIL rst_mid_run: count=%0d addr=%h instr=%h want 0 0 0", fifo_count, fetch_addr, eng_instr); end
    n_checks++; if ({fetch_req, eng_start, busy, done, err_opcode} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_run_ctl: got %b want 0", {fetch_req, eng_start, busy, done, err_opcode}); end
    rst = 1'b1;
    acc_enable = 1'b0;
    force_busy = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_busy_stall();
    test_random();
    test_sync();
    test_err_opcode();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
